// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution layer engine: FSM state
// encoding, stride encoding and the output-map width function.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMG,
        LOAD_FLT,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Only this code selects stride 2; every other stride code means stride 1.
    localparam logic [1:0] STRIDE_2 = 2'd2;

    function automatic int out_w(input int img_w, input int k_w, input int s);
        return (img_w - k_w) / s + 1;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered signed multiply-accumulate; clr together with en loads the
// first product instead of adding, so a new dot product needs no idle cycle.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]    prod_ext_p0;

    assign prod_p0     = a * b;
    assign prod_ext_p0 = ACC_W'(prod_p0);

    // p0 -> p1: accumulator wraps modulo 2^ACC_W
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= clr ? prod_ext_p0 : acc + prod_ext_p0;
        end
    end

endmodule

// File: rtl/conv_layer_engine.sv
// Single convolution layer: loads image and filters over one stream, then emits
// every valid-window dot product. Define CONV_RELU_EN to clamp negative results to 0.
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int K_W    = 4,
    parameter int CH_IN  = 1,
    parameter int N_FILT = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                stride,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_data,
    output logic [$clog2(N_FILT)-1:0] out_filt,
    output logic                      busy,
    output logic                      done
);

    localparam int IMG_N = CH_IN * IMG_W * IMG_W;
    localparam int FLT_N = N_FILT * CH_IN * K_W * K_W;
    localparam int IA_W  = $clog2(IMG_N);
    localparam int FA_W  = $clog2(FLT_N);
    localparam int WA_W  = (IA_W > FA_W) ? IA_W : FA_W;
    localparam int K_CW  = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int CH_CW = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int F_CW  = $clog2(N_FILT);
    localparam int P_CW  = $clog2(IMG_W);
    localparam int OW1   = out_w(IMG_W, K_W, 1);
    localparam int OW2   = out_w(IMG_W, K_W, 2);

    state_t state, nstate;

    logic signed [DATA_W-1:0] img_mem [IMG_N];
    logic signed [DATA_W-1:0] flt_mem [FLT_N];

    logic             s2;
    logic [WA_W-1:0]  wr_addr;
    logic [K_CW-1:0]  kr, kc;
    logic [CH_CW-1:0] ch;
    logic [F_CW-1:0]  filt;
    logic [P_CW-1:0]  orow, ocol, row_base, col_base;
    logic [P_CW-1:0]  ow_last, step;
    logic [IA_W-1:0]  img_addr;
    logic [FA_W-1:0]  flt_addr;

    logic beat, mac_en, first_tap, last_tap, last_filt, last_pos;
    logic signed [DATA_W-1:0] pix_rd, tap_rd;
    logic signed [ACC_W-1:0]  acc;

    assign beat      = in_valid && in_ready;
    assign ow_last   = s2 ? P_CW'(OW2 - 1) : P_CW'(OW1 - 1);
    assign step      = s2 ? P_CW'(2) : P_CW'(1);
    assign first_tap = (kc == '0) && (kr == '0) && (ch == '0);
    assign last_tap  = (kc == K_CW'(K_W - 1)) && (kr == K_CW'(K_W - 1)) && (ch == CH_CW'(CH_IN - 1));
    assign last_filt = (filt == F_CW'(N_FILT - 1));
    assign last_pos  = last_filt && (ocol == ow_last) && (orow == ow_last);

    // Sums stay below the buffer size, so modular address arithmetic is exact.
    assign img_addr = IA_W'(ch) * IA_W'(IMG_W * IMG_W)
                    + (IA_W'(row_base) + IA_W'(kr)) * IA_W'(IMG_W)
                    + IA_W'(col_base) + IA_W'(kc);
    assign flt_addr = FA_W'(filt) * FA_W'(CH_IN * K_W * K_W)
                    + FA_W'(ch) * FA_W'(K_W * K_W)
                    + FA_W'(kr) * FA_W'(K_W) + FA_W'(kc);

    assign pix_rd = img_mem[img_addr];
    assign tap_rd = flt_mem[flt_addr];

    always_ff @(posedge clk) begin
        if (beat && state == LOAD_IMG) img_mem[wr_addr[IA_W-1:0]] <= in_data;
        if (beat && state == LOAD_FLT) flt_mem[wr_addr[FA_W-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate    = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        mac_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nstate = LOAD_IMG;
            end
            LOAD_IMG: begin
                in_ready = 1'b1;
                if (in_valid && wr_addr == WA_W'(IMG_N - 1)) nstate = LOAD_FLT;
            end
            LOAD_FLT: begin
                in_ready = 1'b1;
                if (in_valid && wr_addr == WA_W'(FLT_N - 1)) nstate = MAC;
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_tap) nstate = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) nstate = last_pos ? DONE : MAC;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2       <= 1'b0;
            wr_addr  <= '0;
            kr       <= '0;
            kc       <= '0;
            ch       <= '0;
            filt     <= '0;
            orow     <= '0;
            ocol     <= '0;
            row_base <= '0;
            col_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        s2       <= (stride == STRIDE_2);
                        wr_addr  <= '0;
                        kr       <= '0;
                        kc       <= '0;
                        ch       <= '0;
                        filt     <= '0;
                        orow     <= '0;
                        ocol     <= '0;
                        row_base <= '0;
                        col_base <= '0;
                    end
                end
                LOAD_IMG: if (beat) wr_addr <= (wr_addr == WA_W'(IMG_N - 1)) ? '0 : wr_addr + 1'b1;
                LOAD_FLT: if (beat) wr_addr <= (wr_addr == WA_W'(FLT_N - 1)) ? '0 : wr_addr + 1'b1;
                MAC: begin
                    if (kc == K_CW'(K_W - 1)) begin
                        kc <= '0;
                        if (kr == K_CW'(K_W - 1)) begin
                            kr <= '0;
                            ch <= (ch == CH_CW'(CH_IN - 1)) ? '0 : ch + 1'b1;
                        end else begin
                            kr <= kr + 1'b1;
                        end
                    end else begin
                        kc <= kc + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        // filter innermost, then output column, then output row
                        if (last_filt) begin
                            filt <= '0;
                            if (ocol == ow_last) begin
                                ocol     <= '0;
                                col_base <= '0;
                                if (orow == ow_last) begin
                                    orow     <= '0;
                                    row_base <= '0;
                                end else begin
                                    orow     <= orow + 1'b1;
                                    row_base <= row_base + step;
                                end
                            end else begin
                                ocol     <= ocol + 1'b1;
                                col_base <= col_base + step;
                            end
                        end else begin
                            filt <= filt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(first_tap),
        .en (mac_en),
        .a  (pix_rd),
        .b  (tap_rd),
        .acc(acc)
    );

`ifdef CONV_RELU_EN
    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] x);
        return (x < 0) ? '0 : x;
    endfunction
    assign out_data = relu(acc);
`else
    assign out_data = acc;
`endif

    assign out_filt = filt;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine at default parameters; expected results
// follow CONV_RELU_EN when it is defined for the build.
module tb_conv_layer_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  stride;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_filt;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_mis = 0;
    int got;

    conv_layer_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stride   (stride),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_filt (out_filt),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
        end
    endtask

    // Stream byte idx of a run: 256 image bytes, then 64 filter bytes.
    function automatic logic [7:0] pix(input int mode, input int idx);
        if (idx < 256) begin
            if (mode == 2) return 8'(idx % 128);
            if (mode == 4) return 8'hFF;
            return 8'd1;
        end
        if (mode == 2) return (idx == 256) ? 8'd1 : 8'd0;
        return 8'd1;
    endfunction

    function automatic logic [31:0] exp_val(input int mode, input int k);
        int f;
        int pos;
        f   = k % 4;
        pos = k / 4;
        if (mode == 2) begin
            if (f != 0) return 32'd0;
            return 32'(((pos / 7) * 2 * 16 + (pos % 7) * 2) % 128);
        end
        if (mode == 4) begin
`ifdef CONV_RELU_EN
            return 32'd0;
`else
            return 32'hFFFF_FFF0;
`endif
        end
        return 32'd16;
    endfunction

    task automatic start_run(input logic [1:0] s);
        start  = 1'b1;
        stride = s;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic load(input int mode, input bit disturb);
        int  idx = 0;
        int  cyc = 0;
        bit  took;
        while (idx < 320 && cyc < 2000) begin
            in_valid = ((cyc % 11) != 3);
            in_data  = pix(mode, idx);
            start    = disturb && (idx == 300);
            if (disturb && idx == 300) stride = 2'd2;
            took = in_valid && in_ready;
            step();
            if (took) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("load_beats", 32'(idx), 32'd320);
        check("load_end_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic collect(input int mode, input int limit, input bit bp, output int n_got);
        int   k = 0;
        int   cyc = 0;
        int   dn = 0;
        bit   stalled = 1'b0;
        logic [31:0] pd;
        logic [1:0]  pf;
        pd = '0;
        pf = '0;
        while (k < limit && cyc < 40000) begin
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (done) dn++;
            if (out_valid) begin
                if (stalled) begin
                    check("stall_data", out_data, pd);
                    check("stall_filt", 32'(out_filt), 32'(pf));
                end
                if (out_ready) begin
                    check("res_data", out_data, exp_val(mode, k));
                    check("res_filt", 32'(out_filt), 32'(k % 4));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = out_data;
                    pf = out_filt;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b1;
        check("early_done", 32'(dn), 32'd0);
        n_got = k;
    endtask

    task automatic finish_run(input int n_got, input int n_exp);
        check("result_count", 32'(n_got), 32'(n_exp));
        check("done_pulse", 32'(done), 32'd1);
        step();
        check("done_clear", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stride    = 2'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_filt", 32'(out_filt), 32'd0);
        rst = 1'b0;
        step();

        // data offered while idle must not be stored or counted
        in_valid = 1'b1;
        in_data  = 8'd99;
        repeat (4) step();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // all-ones image and filters, stride 1
        start_run(2'd1);
        load(1, 1'b0);
        collect(1, 676, 1'b0, got);
        finish_run(got, 676);

        // ramp image, single-tap filter 0, stride 2
        start_run(2'd2);
        load(2, 1'b0);
        collect(2, 196, 1'b0, got);
        finish_run(got, 196);

        // random backpressure on the all-ones run
        start_run(2'd1);
        load(1, 1'b0);
        collect(1, 676, 1'b1, got);
        finish_run(got, 676);

        // negative image: first results then abort
        start_run(2'd1);
        load(4, 1'b0);
        collect(4, 20, 1'b0, got);
        check("neg_count", 32'(got), 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // reset during the MAC of the 10th result
        start_run(2'd3);
        load(1, 1'b0);
        collect(1, 9, 1'b0, got);
        check("abort_count", 32'(got), 32'd9);
        repeat (5) step();
        check("mid_mac_valid", 32'(out_valid), 32'd0);
        check("mid_mac_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();
        check("abort_done_after", 32'(done), 32'd0);

        // start pulse during filter load and stride change mid-run are ignored
        start_run(2'd1);
        load(1, 1'b1);
        collect(1, 676, 1'b0, got);
        finish_run(got, 676);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
